img_pxl_idx: RTL and testbench

IMG_PXL_IDX -- requirements
Module: img_pxl_idx

---
 rtl/img_pxl_idx_pkg.sv | 34 +++
 rtl/img_pxl_idx_skid.sv | 80 ++++++++
 rtl/img_pxl_idx.sv | 198 +++++++++++++++++++
 tb/tb_img_pxl_idx.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pxl_idx_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ImgRszPkg -- shared image widths, pixel-indexer state and skid-entry types.
// Revision: 1.0
// -----------------------------------------------------------------------------
package ImgRszPkg;

    localparam int IMG_WIDTH_IDX_W    = 12;
    localparam int IMG_HEIGHT_IDX_W   = 12;
    localparam int PXL_PRIM_COLOR_W   = 8;
    localparam int PXL_PRIM_COLOR_NUM = 3;
    localparam int PXL_DATA_W         = PXL_PRIM_COLOR_W * PXL_PRIM_COLOR_NUM;

    localparam logic [1:0] PXL_IDX_ST_IDLE   = 2'd0;
    localparam logic [1:0] PXL_IDX_ST_ACTIVE = 2'd1;
    localparam logic [1:0] PXL_IDX_ST_DROP   = 2'd2;

    typedef enum logic [1:0] {
        PXL_IDX_IDLE   = PXL_IDX_ST_IDLE,
        PXL_IDX_ACTIVE = PXL_IDX_ST_ACTIVE,
        PXL_IDX_DROP   = PXL_IDX_ST_DROP
    } PxlIdxState_t;

    // Frame config rides along with every pixel so queued pixels keep their own frame's size.
    typedef struct packed {
        logic [PXL_DATA_W-1:0]       data;
        logic [IMG_WIDTH_IDX_W-1:0]  x;
        logic [IMG_HEIGHT_IDX_W-1:0] y;
        logic [IMG_WIDTH_IDX_W-1:0]  width;
        logic [IMG_HEIGHT_IDX_W-1:0] height;
    } PxlSkidEnt_t;

endpackage
`default_nettype wire

// File: rtl/img_pxl_idx_skid.sv
`default_nettype none
// -----------------------------------------------------------------------------
// img_pxl_skid -- DEPTH-entry circular skid buffer with a registered ready.
// Revision: 1.0
// -----------------------------------------------------------------------------
module img_pxl_skid
    import ImgRszPkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_vld_i,
    input  PxlSkidEnt_t in_ent_i,
    output logic        in_rdy_o,
    output logic        out_vld_o,
    output PxlSkidEnt_t out_ent_o,
    input  logic        out_rdy_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    PxlSkidEnt_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;
    logic             push;
    logic             pop;

    assign push      = in_vld_i & rdy_q;
    assign out_vld_o = (cnt_q != '0);
    assign pop       = out_vld_o & out_rdy_i;
    assign out_ent_o = mem_q[rd_ptr_q];
    assign in_rdy_o  = rdy_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Ready is registered from the next occupancy, so it never depends on in_vld_i combinationally.
        rdy_d = (cnt_d != FULL_CNT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_ent_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/img_pxl_idx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// img_pxl_idx -- tags a raw pixel stream with (x,y) coordinates and frame config.
// Revision: 1.0
// -----------------------------------------------------------------------------
module img_pxl_idx
    import ImgRszPkg::*;
#(
    parameter int SKID_DEPTH = 2
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [IMG_WIDTH_IDX_W-1:0]  CfgWidth,
    input  logic [IMG_HEIGHT_IDX_W-1:0] CfgHeight,
    input  logic [PXL_DATA_W-1:0]       InPxlData,
    input  logic                        InPxlSof,
    input  logic                        InPxlEol,
    input  logic                        InPxlVld,
    output logic                        InPxlRdy,
    output logic [IMG_WIDTH_IDX_W-1:0]  ImgWidth,
    output logic [IMG_HEIGHT_IDX_W-1:0] ImgHeight,
    output logic [PXL_DATA_W-1:0]       PxlData,
    output logic [IMG_WIDTH_IDX_W-1:0]  PxlX,
    output logic [IMG_HEIGHT_IDX_W-1:0] PxlY,
    output logic                        PxlVld,
    input  logic                        PxlRdy,
    output logic                        FrmDone,
    output logic                        ErrSof,
    output logic                        ErrLine,
    output logic                        ErrCfg,
    input  logic                        ErrClr
);

    PxlIdxState_t                state_q, state_d;
    logic [IMG_WIDTH_IDX_W-1:0]  xcnt_q, xcnt_d;
    logic [IMG_HEIGHT_IDX_W-1:0] ycnt_q, ycnt_d;
    logic [IMG_WIDTH_IDX_W-1:0]  wid_q, wid_d;
    logic [IMG_HEIGHT_IDX_W-1:0] hgt_q, hgt_d;
    logic                        frm_done_q, frm_done_d;
    logic                        err_sof_q, err_sof_d;
    logic                        err_line_q, err_line_d;
    logic                        err_cfg_q, err_cfg_d;

    logic                        acc;
    logic                        fwd;
    logic                        track;
    logic                        end_line;
    logic                        set_sof, set_line, set_cfg;
    logic [IMG_WIDTH_IDX_W-1:0]  x_e, w_e;
    logic [IMG_HEIGHT_IDX_W-1:0] y_e, h_e;
    PxlSkidEnt_t                 in_ent;
    PxlSkidEnt_t                 out_ent;

    assign acc = InPxlVld & InPxlRdy;

    always_comb begin
        state_d    = state_q;
        xcnt_d     = xcnt_q;
        ycnt_d     = ycnt_q;
        wid_d      = wid_q;
        hgt_d      = hgt_q;
        frm_done_d = 1'b0;
        fwd        = 1'b0;
        track      = 1'b0;
        end_line   = 1'b0;
        set_sof    = 1'b0;
        set_line   = 1'b0;
        set_cfg    = 1'b0;
        x_e        = xcnt_q;
        y_e        = ycnt_q;
        w_e        = wid_q;
        h_e        = hgt_q;

        if (acc) begin
            if (InPxlSof) begin
                if ((CfgWidth == '0) || (CfgHeight == '0)) begin
                    set_cfg = 1'b1;
                    state_d = PXL_IDX_IDLE;
                    xcnt_d  = '0;
                    ycnt_d  = '0;
                end else begin
                    // A valid SOF restarts the frame from any state with the new config.
                    set_sof = (state_q != PXL_IDX_IDLE);
                    wid_d   = CfgWidth;
                    hgt_d   = CfgHeight;
                    x_e     = '0;
                    y_e     = '0;
                    w_e     = CfgWidth;
                    h_e     = CfgHeight;
                    fwd     = 1'b1;
                    track   = 1'b1;
                end
            end else begin
                case (state_q)
                    PXL_IDX_ACTIVE: begin
                        fwd   = 1'b1;
                        track = 1'b1;
                    end
                    PXL_IDX_DROP: begin
                        end_line = InPxlEol;
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (track) begin
            xcnt_d  = x_e;
            ycnt_d  = y_e;
            state_d = PXL_IDX_ACTIVE;
            if (InPxlEol) begin
                set_line = (x_e != (w_e - 1'b1));
                end_line = 1'b1;
            end else if (x_e == (w_e - 1'b1)) begin
                set_line = 1'b1;
                state_d  = PXL_IDX_DROP;
            end else begin
                xcnt_d = x_e + 1'b1;
            end
        end

        if (end_line) begin
            xcnt_d = '0;
            if (y_e == (h_e - 1'b1)) begin
                frm_done_d = 1'b1;
                ycnt_d     = '0;
                state_d    = PXL_IDX_IDLE;
            end else begin
                ycnt_d  = y_e + 1'b1;
                state_d = PXL_IDX_ACTIVE;
            end
        end

        // Set has priority over a coincident clear.
        err_sof_d  = (err_sof_q  & ~ErrClr) | set_sof;
        err_line_d = (err_line_q & ~ErrClr) | set_line;
        err_cfg_d  = (err_cfg_q  & ~ErrClr) | set_cfg;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= PXL_IDX_IDLE;
            xcnt_q     <= '0;
            ycnt_q     <= '0;
            wid_q      <= '0;
            hgt_q      <= '0;
            frm_done_q <= 1'b0;
            err_sof_q  <= 1'b0;
            err_line_q <= 1'b0;
            err_cfg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            xcnt_q     <= xcnt_d;
            ycnt_q     <= ycnt_d;
            wid_q      <= wid_d;
            hgt_q      <= hgt_d;
            frm_done_q <= frm_done_d;
            err_sof_q  <= err_sof_d;
            err_line_q <= err_line_d;
            err_cfg_q  <= err_cfg_d;
        end
    end

    always_comb begin
        in_ent        = '0;
        in_ent.data   = InPxlData;
        in_ent.x      = x_e;
        in_ent.y      = y_e;
        in_ent.width  = w_e;
        in_ent.height = h_e;
    end

    img_pxl_skid #(
        .DEPTH     (SKID_DEPTH)
    ) u_skid (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_vld_i  (InPxlVld & fwd),
        .in_ent_i  (in_ent),
        .in_rdy_o  (InPxlRdy),
        .out_vld_o (PxlVld),
        .out_ent_o (out_ent),
        .out_rdy_i (PxlRdy)
    );

    assign PxlData   = out_ent.data;
    assign PxlX      = out_ent.x;
    assign PxlY      = out_ent.y;
    assign ImgWidth  = out_ent.width;
    assign ImgHeight = out_ent.height;
    assign FrmDone   = frm_done_q;
    assign ErrSof    = err_sof_q;
    assign ErrLine   = err_line_q;
    assign ErrCfg    = err_cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_img_pxl_idx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_img_pxl_idx -- directed frames checked against a frame-level reference model.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_img_pxl_idx;
    import ImgRszPkg::*;

    localparam int DEPTH = 2;
    localparam int WW    = IMG_WIDTH_IDX_W;
    localparam int HW    = IMG_HEIGHT_IDX_W;
    localparam int DW    = PXL_DATA_W;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [WW-1:0] CfgWidth = '0;
    logic [HW-1:0] CfgHeight = '0;
    logic [DW-1:0] InPxlData = '0;
    logic          InPxlSof = 1'b0;
    logic          InPxlEol = 1'b0;
    logic          InPxlVld = 1'b0;
    logic          InPxlRdy;
    logic [WW-1:0] ImgWidth;
    logic [HW-1:0] ImgHeight;
    logic [DW-1:0] PxlData;
    logic [WW-1:0] PxlX;
    logic [HW-1:0] PxlY;
    logic          PxlVld;
    logic          PxlRdy = 1'b1;
    logic          FrmDone;
    logic          ErrSof, ErrLine, ErrCfg;
    logic          ErrClr = 1'b0;

    always #5 Clk = ~Clk;

    img_pxl_idx #(.SKID_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .CfgWidth(CfgWidth), .CfgHeight(CfgHeight),
        .InPxlData(InPxlData), .InPxlSof(InPxlSof), .InPxlEol(InPxlEol),
        .InPxlVld(InPxlVld), .InPxlRdy(InPxlRdy), .ImgWidth(ImgWidth),
        .ImgHeight(ImgHeight), .PxlData(PxlData), .PxlX(PxlX), .PxlY(PxlY),
        .PxlVld(PxlVld), .PxlRdy(PxlRdy), .FrmDone(FrmDone), .ErrSof(ErrSof),
        .ErrLine(ErrLine), .ErrCfg(ErrCfg), .ErrClr(ErrClr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame/line rules on plain integers
    typedef struct packed {
        logic [DW-1:0] d;
        logic [WW-1:0] x;
        logic [HW-1:0] y;
        logic [WW-1:0] w;
        logic [HW-1:0] h;
    } exp_t;

    exp_t q[$];
    int   m_mode = 0;          // 0: waiting for SOF, 1: inside a line, 2: skipping to EOL
    int   m_x, m_y, m_w, m_h;
    bit   e_sof, e_line, e_cfg;
    bit   m_fd;
    int   fd_exp = 0;
    int   fd_seen = 0;
    int   fwd_cnt = 0;
    int   pop_cnt = 0;
    int   seq = 1;

    task automatic next_line();
        m_x = 0;
        m_y = m_y + 1;
        if (m_y == m_h) begin
            m_fd = 1;
            fd_exp++;
            m_mode = 0;
        end else begin
            m_mode = 1;
        end
    endtask

    task automatic model_accept(input bit sof, input bit eol, input logic [DW-1:0] d,
                                input bit clr, output bit fwd);
        exp_t e;
        fwd  = 0;
        m_fd = 0;
        if (clr) begin
            e_sof = 0; e_line = 0; e_cfg = 0;
        end
        if (sof) begin
            if (CfgWidth == 0 || CfgHeight == 0) begin
                e_cfg  = 1;
                m_mode = 0;
                return;
            end
            if (m_mode != 0) e_sof = 1;
            m_w = int'(CfgWidth);
            m_h = int'(CfgHeight);
            m_x = 0;
            m_y = 0;
            m_mode = 1;
        end else if (m_mode == 0) begin
            return;
        end else if (m_mode == 2) begin
            if (eol) next_line();
            return;
        end
        fwd = 1;
        e.d = d; e.x = WW'(m_x); e.y = HW'(m_y); e.w = WW'(m_w); e.h = HW'(m_h);
        q.push_back(e);
        if (eol) begin
            if (m_x + 1 != m_w) e_line = 1;
            next_line();
        end else if (m_x + 1 == m_w) begin
            e_line = 1;
            m_mode = 2;
        end else begin
            m_x = m_x + 1;
        end
    endtask

    // ---------------- output compare process
    int   cyc = 0;
    logic rst_hi = 1'b0;
    bit   tog = 0;
    bit   hold_v = 0;
    logic [63:0] hold_p;
    int   obs_n = 0;
    int   obs_x[64], obs_y[64], obs_w[64], obs_cyc[64];
    int   occ;
    exp_t ce;

    always @(posedge Clk) begin
        cyc    <= cyc + 1;
        rst_hi <= Reset;
    end

    always @(posedge Clk) begin
        #1;
        PxlRdy = tog ? ~PxlRdy : 1'b1;
    end

    always @(negedge Clk) begin
        if (FrmDone) fd_seen++;
        if (rst_hi) begin
            occ = fwd_cnt - pop_cnt;
            chk("in_rdy_vs_occupancy", InPxlRdy, (occ < DEPTH));
            if (hold_v) begin
                chk("stall_vld", PxlVld, 1);
                chk("stall_payload", {16'd0, PxlData, PxlX, PxlY}, hold_p);
            end
            if (PxlVld && PxlRdy) begin
                chk("out_expected", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    ce = q.pop_front();
                    chk("px_data", PxlData, ce.d);
                    chk("px_x", PxlX, ce.x);
                    chk("px_y", PxlY, ce.y);
                    chk("img_w", ImgWidth, ce.w);
                    chk("img_h", ImgHeight, ce.h);
                end
                if (obs_n < 64) begin
                    obs_x[obs_n] = int'(PxlX);
                    obs_y[obs_n] = int'(PxlY);
                    obs_w[obs_n] = int'(ImgWidth);
                    obs_cyc[obs_n] = cyc;
                    obs_n++;
                end
                pop_cnt++;
            end
            hold_v = PxlVld && !PxlRdy;
            hold_p = {16'd0, PxlData, PxlX, PxlY};
        end
    end

    // ---------------- stimulus helpers
    task automatic send(input bit sof, input bit eol, input bit clr);
        bit f;
        int t;
        logic [DW-1:0] d;
        d = DW'(seq);
        seq++;
        InPxlVld = 1; InPxlSof = sof; InPxlEol = eol; InPxlData = d; ErrClr = clr;
        t = 0;
        while (!InPxlRdy && t < 50) begin
            @(negedge Clk);
            t++;
        end
        chk("in_rdy_wait", InPxlRdy, 1);
        model_accept(sof, eol, d, clr, f);
        @(posedge Clk);
        if (f) fwd_cnt++;
        @(negedge Clk);
        InPxlVld = 0; InPxlSof = 0; InPxlEol = 0; ErrClr = 0;
        chk("frm_done", FrmDone, m_fd);
        chk("err_sof", ErrSof, e_sof);
        chk("err_line", ErrLine, e_line);
        chk("err_cfg", ErrCfg, e_cfg);
    endtask

    task automatic send_line(input int n, input bit sof_first);
        for (int i = 0; i < n; i++) send(sof_first && (i == 0), i == n - 1, 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("drain", q.size(), 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic clear_errs();
        ErrClr = 1;
        @(negedge Clk);
        ErrClr = 0;
        e_sof = 0; e_line = 0; e_cfg = 0;
        chk("errs_cleared", {ErrSof, ErrLine, ErrCfg}, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_pxl_vld", PxlVld, 0);
        chk("rst_in_rdy", InPxlRdy, 0);
        chk("rst_frm_done", FrmDone, 0);
        chk("rst_errs", {ErrSof, ErrLine, ErrCfg}, 0);
        chk("rst_img_wh", {ImgWidth, ImgHeight}, 0);
        chk("rst_pxl_xy", {PxlX, PxlY}, 0);
        chk("rst_pxl_data", PxlData, 0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset = 0;
        q.delete();
        pop_cnt = fwd_cnt;
        hold_v = 0;
        m_mode = 0;
        e_sof = 0; e_line = 0; e_cfg = 0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge Clk);
        chk_reset_outputs();
        #2;
        Reset = 1;
        @(negedge Clk);
        chk("rdy_after_reset", InPxlRdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int ex_x[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ex_y[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int fd0;

    initial begin
        repeat (2) @(negedge Clk);
        #1;
        chk_reset_outputs();
        #1;
        Reset = 1;
        @(negedge Clk);
        chk("rdy_after_reset", InPxlRdy, 1);

        // 4x2 frame, PxlRdy held high
        CfgWidth = 4; CfgHeight = 2;
        obs_n = 0; fd0 = fd_seen;
        send_line(4, 1);
        send_line(4, 0);
        drain();
        chk("t1_count", obs_n, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_x", obs_x[i], ex_x[i]);
            chk("t1_y", obs_y[i], ex_y[i]);
        end
        for (int i = 1; i < 8; i++) chk("t1_no_bubble", obs_cyc[i] - obs_cyc[i-1], 1);
        chk("t1_frmdone_once", fd_seen - fd0, 1);

        // same frame, PxlRdy toggling
        tog = 1;
        obs_n = 0; fd0 = fd_seen;
        send_line(4, 1);
        send_line(4, 0);
        drain();
        tog = 0;
        chk("t2_count", obs_n, 8);
        for (int i = 0; i < 8; i++) chk("t2_xy", {obs_x[i], obs_y[i]}, {ex_x[i], ex_y[i]});
        chk("t2_frmdone_once", fd_seen - fd0, 1);

        // short line: EOL at x=2
        clear_errs();
        obs_n = 0;
        send_line(3, 1);
        chk("t3_err_line", ErrLine, 1);
        send_line(4, 0);
        drain();
        chk("t3_count", obs_n, 7);
        chk("t3_next_xy", {obs_x[3], obs_y[3]}, {32'd0, 32'd1});

        // long line: six pixels, EOL on the sixth
        clear_errs();
        obs_n = 0;
        send_line(6, 1);
        chk("t4_err_line", ErrLine, 1);
        send_line(4, 0);
        drain();
        chk("t4_count", obs_n, 8);
        chk("t4_next_xy", {obs_x[4], obs_y[4]}, {32'd0, 32'd1});

        // SOF injected at (2,1)
        clear_errs();
        obs_n = 0; fd0 = fd_seen;
        send_line(4, 1);
        send(0, 0, 0);
        send(0, 0, 0);
        send(1, 0, 0);
        chk("t5_err_sof", ErrSof, 1);
        send(0, 0, 0); send(0, 0, 0); send(0, 1, 0);
        send_line(4, 0);
        drain();
        chk("t5_count", obs_n, 14);
        chk("t5_restart_xy", {obs_x[6], obs_y[6]}, {32'd0, 32'd0});
        chk("t5_after_xy", {obs_x[7], obs_y[7]}, {32'd1, 32'd0});
        chk("t5_frmdone_once", fd_seen - fd0, 1);

        // zero-width config on SOF
        clear_errs();
        obs_n = 0;
        CfgWidth = 0; CfgHeight = 2;
        send(1, 0, 0);
        chk("t6_err_cfg", ErrCfg, 1);
        CfgWidth = 4;
        send(0, 1, 0);
        drain();
        chk("t6_count", obs_n, 0);

        // single-pixel frame
        clear_errs();
        obs_n = 0; fd0 = fd_seen;
        CfgWidth = 1; CfgHeight = 1;
        send(1, 1, 0);
        drain();
        chk("t7_count", obs_n, 1);
        chk("t7_xy_w", {obs_x[0], obs_y[0], obs_w[0]}, {32'd0, 32'd0, 32'd1});
        chk("t7_frmdone_once", fd_seen - fd0, 1);
        chk("t7_errs", {ErrSof, ErrLine, ErrCfg}, 0);

        // back-to-back frames of different width while stalling
        tog = 1;
        obs_n = 0;
        CfgWidth = 4; CfgHeight = 1;
        send_line(4, 1);
        CfgWidth = 2;
        send_line(2, 1);
        drain();
        tog = 0;
        chk("t8_count", obs_n, 6);
        chk("t8_w_first", obs_w[3], 4);
        chk("t8_w_second", obs_w[4], 2);

        // ErrClr coinciding with a short-line event
        clear_errs();
        CfgWidth = 4; CfgHeight = 1;
        send(0, 0, 0);
        send(1, 1, 1);
        chk("t9_set_wins", ErrLine, 1);
        drain();

        // reset mid-frame at (1,1)
        CfgWidth = 4; CfgHeight = 2;
        send_line(4, 1);
        send(0, 0, 0);
        do_reset();
        obs_n = 0;
        send(0, 0, 0);
        send(0, 0, 0);
        send(0, 1, 0);
        drain();
        chk("t10_discard", obs_n, 0);
        CfgWidth = 3; CfgHeight = 2;
        send_line(3, 1);
        send_line(3, 0);
        drain();
        chk("t10_count", obs_n, 6);
        chk("t10_first_xyw", {obs_x[0], obs_y[0], obs_w[0]}, {32'd0, 32'd0, 32'd3});

        chk("frmdone_total", fd_seen, fd_exp);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
